// File: rtl/snake_pkg.sv
// Shared direction encodings and queue states for the snake game.
// Directions wrap so that the opposite of any heading differs only in bit 1.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } qstate_t;

    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer.
// Emits a one-cycle press pulse on the same edge the level rises.
module btn_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized input disagrees with the level
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/dir_cmd_arbiter.sv
// Turns debounced button presses into a filtered two-entry direction queue,
// committing the head to NSM_state on each game tick.
module dir_cmd_arbiter
    import snake_pkg::*;
#(
    parameter int DB_CYCLES = 250000,
    parameter int QDEPTH    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTNU,
    input  logic       BTNR,
    input  logic       BTND,
    input  logic       BTNL,
    input  logic       TICK,
    input  logic       GAME_EN,
    output logic [1:0] NSM_state,
    output logic       DIR_VALID,
    output logic [1:0] Q_LEVEL,
    output logic       DROP
);

    localparam logic [1:0] QMAX = 2'(QDEPTH);

    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {BTNU, BTNR, BTND, BTNL};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (CLK),
            .rst_n  (RESET),
            .btn_raw(btn_raw[i]),
            .press  (press[i])
        );
    end

    qstate_t state_q, state_d;
    dir_t    q0_q, q0_d;
    dir_t    q1_q, q1_d;
    dir_t    nsm_q, nsm_d;
    logic    dir_valid_q, dir_valid_d;
    logic    drop_q, drop_d;

    dir_t ev;
    dir_t ref_dir;
    logic ev_any, ev_multi;
    logic push, pop, reject;

    always_comb begin
        ev_any   = |press;
        ev_multi = (press & (press - 4'd1)) != 4'd0;

        if (press[3])      ev = DIR_UP;
        else if (press[2]) ev = DIR_RIGHT;
        else if (press[1]) ev = DIR_DOWN;
        else               ev = DIR_LEFT;

        // New presses are judged against the last direction that will be taken
        if (state_q == Q_EMPTY)     ref_dir = nsm_q;
        else if (state_q == Q_FULL) ref_dir = q1_q;
        else                        ref_dir = q0_q;

        push        = 1'b0;
        pop         = 1'b0;
        reject      = 1'b0;
        state_d     = state_q;
        q0_d        = q0_q;
        q1_d        = q1_q;
        nsm_d       = nsm_q;
        dir_valid_d = 1'b0;
        drop_d      = 1'b0;

        if (!GAME_EN) begin
            state_d = Q_EMPTY;
        end else begin
            pop = TICK && (state_q != Q_EMPTY);
            if (ev_any && (ev != ref_dir)) begin
                if ((ev == opposite_dir(ref_dir)) || (state_q == QMAX))
                    reject = 1'b1;
                else
                    push = 1'b1;
            end
            drop_d = ev_multi || reject;

            if (pop) begin
                nsm_d       = q0_q;
                dir_valid_d = 1'b1;
            end

            unique case (state_q)
                Q_EMPTY: begin
                    if (push) begin
                        q0_d    = ev;
                        state_d = Q_ONE;
                    end
                end
                Q_ONE: begin
                    if (push && pop) begin
                        q0_d = ev;
                    end else if (push) begin
                        q1_d    = ev;
                        state_d = Q_FULL;
                    end else if (pop) begin
                        state_d = Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (pop) begin
                        q0_d    = q1_q;
                        state_d = Q_ONE;
                    end
                end
                default: state_d = Q_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= Q_EMPTY;
            q0_q        <= DIR_UP;
            q1_q        <= DIR_UP;
            nsm_q       <= DIR_RIGHT;
            dir_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            nsm_q       <= nsm_d;
            dir_valid_q <= dir_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign NSM_state = nsm_q;
    assign DIR_VALID = dir_valid_q;
    assign Q_LEVEL   = state_q;
    assign DROP      = drop_q;

endmodule

// File: tb/tb_dir_cmd_arbiter.sv
// Directed bench: stimulus pushes expected DIR_VALID/DROP events into
// queues that a negedge monitor drains, plus inline level checks.
module tb_dir_cmd_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BTNU = 1'b0, BTNR = 1'b0, BTND = 1'b0, BTNL = 1'b0;
    logic       TICK = 1'b0;
    logic       GAME_EN = 1'b0;
    logic [1:0] NSM_state;
    logic       DIR_VALID;
    logic [1:0] Q_LEVEL;
    logic       DROP;

    int errors = 0;
    int checks = 0;

    int exp_dir[$];
    int exp_drop_q[$];

    always #5 CLK = ~CLK;

    dir_cmd_arbiter #(.DB_CYCLES(4), .QDEPTH(2)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTNU     (BTNU),
        .BTNR     (BTNR),
        .BTND     (BTND),
        .BTNL     (BTNL),
        .TICK     (TICK),
        .GAME_EN  (GAME_EN),
        .NSM_state(NSM_state),
        .DIR_VALID(DIR_VALID),
        .Q_LEVEL  (Q_LEVEL),
        .DROP     (DROP)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // m = {U,R,D,L}; tick_push puts TICK on the edge that pushes the event
    task automatic press(input logic [3:0] m, input bit tick_push,
                         input bit chk_lat);
        int qb;
        qb = Q_LEVEL;
        {BTNU, BTNR, BTND, BTNL} = m;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            if (chk_lat && k == 6) chk("lat_before", Q_LEVEL, qb);
            if (chk_lat && k == 7) chk("lat_at7", Q_LEVEL, qb + 1);
            if (tick_push && k == 6) TICK = 1'b1;
            if (k == 7) TICK = 1'b0;
        end
        {BTNU, BTNR, BTND, BTNL} = 4'b0000;
        step(8);
    endtask

    task automatic tick();
        TICK = 1'b1;
        step(1);
        TICK = 1'b0;
        step(2);
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (DIR_VALID === 1'b1) begin
                if (exp_dir.size() == 0)
                    chk("dir_valid_unexpected", int'(DIR_VALID), 0);
                else
                    chk("nsm_on_valid", NSM_state, exp_dir.pop_front());
            end
            if (DROP === 1'b1) begin
                if (exp_drop_q.size() == 0)
                    chk("drop_unexpected", int'(DROP), 0);
                else
                    chk("qlevel_on_drop", Q_LEVEL, exp_drop_q.pop_front());
            end
        end
    end

    initial begin : stim
        RESET = 1'b1;
        #1 RESET = 1'b0;
        #1;
        chk("rst_async_nsm", NSM_state, 1);
        chk("rst_async_q", Q_LEVEL, 0);
        step(2);
        RESET = 1'b1;
        GAME_EN = 1'b1;
        step(2);
        chk("rst_nsm", NSM_state, 1);
        chk("rst_q", Q_LEVEL, 0);
        chk("rst_drop", DROP, 0);
        chk("rst_dv", DIR_VALID, 0);

        // Latency, then commit UP
        press(4'b1000, 1'b0, 1'b1);
        chk("u_queued", Q_LEVEL, 1);
        exp_dir.push_back(0);
        tick();
        chk("u_commit", NSM_state, 0);
        chk("u_q0", Q_LEVEL, 0);

        // Same as reference: silently ignored
        press(4'b1000, 1'b0, 1'b0);
        chk("same_ignored", Q_LEVEL, 0);

        press(4'b0100, 1'b0, 1'b0);
        exp_dir.push_back(1);
        tick();
        chk("r_commit", NSM_state, 1);

        // Opposite of RIGHT
        exp_drop_q.push_back(0);
        press(4'b0001, 1'b0, 1'b0);
        chk("opp_q", Q_LEVEL, 0);

        // U and L together: U wins, one drop
        exp_drop_q.push_back(1);
        press(4'b1001, 1'b0, 1'b0);
        chk("multi_q", Q_LEVEL, 1);

        press(4'b0001, 1'b0, 1'b0);
        chk("l_full", Q_LEVEL, 2);
        exp_drop_q.push_back(2);
        press(4'b0010, 1'b0, 1'b0);
        chk("d_dropped", Q_LEVEL, 2);
        exp_dir.push_back(0);
        tick();
        chk("pop1_q", Q_LEVEL, 1);
        exp_dir.push_back(3);
        tick();
        chk("pop2_nsm", NSM_state, 3);
        chk("pop2_q", Q_LEVEL, 0);

        // Push and pop on the same edge
        press(4'b1000, 1'b0, 1'b0);
        exp_dir.push_back(0);
        press(4'b0100, 1'b1, 1'b0);
        chk("pushpop_q", Q_LEVEL, 1);
        chk("pushpop_nsm", NSM_state, 0);
        exp_dir.push_back(1);
        tick();
        chk("pushpop_r", NSM_state, 1);

        // Tick on empty queue coincident with push: no bypass
        press(4'b0010, 1'b1, 1'b0);
        chk("nobypass_q", Q_LEVEL, 1);
        chk("nobypass_nsm", NSM_state, 1);
        exp_dir.push_back(2);
        tick();
        chk("d_commit", NSM_state, 2);

        // Short glitch must not register
        BTNR = 1'b1;
        step(2);
        BTNR = 1'b0;
        step(12);
        chk("glitch_q", Q_LEVEL, 0);
        chk("glitch_nsm", NSM_state, 2);

        // Fill then reset mid-cycle
        press(4'b0001, 1'b0, 1'b0);
        press(4'b1000, 1'b0, 1'b0);
        chk("fill_q", Q_LEVEL, 2);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        chk("midrst_q", Q_LEVEL, 0);
        chk("midrst_nsm", NSM_state, 1);
        chk("midrst_dv", DIR_VALID, 0);
        step(2);
        RESET = 1'b1;
        step(3);

        // Disable flushes, ignores ticks and presses
        press(4'b1000, 1'b0, 1'b0);
        press(4'b0001, 1'b0, 1'b0);
        chk("en_full", Q_LEVEL, 2);
        GAME_EN = 1'b0;
        step(1);
        chk("flush_q", Q_LEVEL, 0);
        tick();
        chk("dis_tick_nsm", NSM_state, 1);
        press(4'b0010, 1'b0, 1'b0);
        chk("dis_press_q", Q_LEVEL, 0);
        GAME_EN = 1'b1;
        step(2);
        tick();
        chk("empty_tick_nsm", NSM_state, 1);

        step(4);
        chk("dir_events_left", exp_dir.size(), 0);
        chk("drop_events_left", exp_drop_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dir_cmd_arbiter.md
DIR_CMD_ARBITER -- requirements
Module: dir_cmd_arbiter

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 250000, number of consecutive stable samples before a button level is accepted.
REQ-002 SHALL have parameter QDEPTH, default 2, depth of the pending-direction queue, fixed at 2 in this revision.
REQ-003 SHALL have port CLK  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports BTNU, BTNR, BTND, BTNL  input  1 each  raw asynchronous push buttons.
REQ-006 SHALL have port TICK  input  1  one-cycle game-step strobe from the frame timer.
REQ-007 SHALL have port GAME_EN  input  1  high = game running.
REQ-008 SHALL have port NSM_state  output  2  committed direction: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.
REQ-009 SHALL have port DIR_VALID  output  1  one-cycle pulse when NSM_state is updated.
REQ-010 SHALL have port Q_LEVEL  output  2  queue occupancy, 0..2.
REQ-011 SHALL have port DROP  output  1  one-cycle pulse when a press event is discarded.

Function
REQ-012 SHALL pass each button through a 2-FF synchronizer and then a debouncer; the debounced level changes only after DB_CYCLES consecutive identical synchronized samples.
REQ-013 SHALL treat a 0->1 transition of a debounced level as a press event; a release SHALL generate no event.
REQ-014 SHALL, when several press events occur in one cycle, accept only the highest-priority one (U > R > D > L) and pulse DROP once.
REQ-015 SHALL compare the accepted event against a reference direction: the queue tail if Q_LEVEL>0, otherwise NSM_state.
REQ-016 SHALL discard an event equal to the reference direction without a DROP pulse.
REQ-017 SHALL discard an event opposite to the reference direction (UP/DOWN, LEFT/RIGHT) and pulse DROP.
REQ-018 SHALL discard an event arriving with Q_LEVEL=2 and pulse DROP.
REQ-019 SHALL otherwise push the event onto the queue; the queue FSM has states EMPTY, ONE and FULL, and Q_LEVEL reflects the state in the cycle after the push.
REQ-020 SHALL, on a clock edge with TICK=1, GAME_EN=1 and Q_LEVEL>0, pop the queue head into NSM_state, with DIR_VALID high for exactly the following cycle.
REQ-021 SHALL perform TICK with Q_LEVEL=0 as a no-op: NSM_state is held and DIR_VALID stays 0.
REQ-022 SHALL perform a push and a pop in the same cycle together, with Q_LEVEL unchanged; with Q_LEVEL=0, the event is queued and the tick does not bypass the queue.
REQ-023 SHALL, while GAME_EN=0, flush the queue to EMPTY, ignore TICK, hold NSM_state and ignore press events without a DROP pulse.
REQ-024 SHALL have a press-to-queue latency of 2 + DB_CYCLES + 1 cycles from the first stable high raw sample.

Reset
REQ-025 SHALL, while RESET=0, asynchronously force NSM_state=01 (RIGHT), DIR_VALID=0, Q_LEVEL=0, DROP=0, the queue to EMPTY, and all synchronizers, debounced levels and counters to 0.
REQ-026 SHALL restart from the reset state when RESET is asserted mid-operation; queued directions are lost and no DIR_VALID pulse is produced.

Structure
REQ-027 SHALL place the direction encodings DIR_UP/RIGHT/DOWN/LEFT, the 2-bit direction typedef and the opposite-direction function in the shared package snake_pkg.
REQ-028 SHALL implement synchronizer plus debouncer as sub-module btn_debounce, instantiated 4x; arbitration, filtering and the queue stay in dir_cmd_arbiter.

Verification (DB_CYCLES=4)
REQ-029 SHALL cover: reset released, no input -> NSM_state=01, Q_LEVEL=0, DROP=0, DIR_VALID=0.
REQ-030 SHALL cover: BTNU high 10 cycles -> Q_LEVEL=1 at cycle 7; then TICK -> NSM_state=00 and a 1-cycle DIR_VALID pulse.
REQ-031 SHALL cover: from RIGHT with queue empty, press BTNL -> DROP pulse, Q_LEVEL stays 0; BTNU and BTNL rising in the same cycle -> UP queued plus 1 DROP pulse.
REQ-032 SHALL cover: press U, L, D sequentially with no TICK -> Q_LEVEL=2 and D dropped; two TICKs -> NSM_state 00, then 11.
REQ-033 SHALL cover: a 2-cycle BTNR glitch -> no event; queue FULL then RESET low mid-cycle -> Q_LEVEL=0, NSM_state=01 immediately.
REQ-034 SHALL cover: GAME_EN low with Q_LEVEL=2 -> Q_LEVEL=0 next cycle; TICK while GAME_EN=0 -> no DIR_VALID.
